axi_lite_bram_ctrl_pipe: RTL and testbench

- AXI-lite device-side to single-port BRAM controller. Successor to the fixed-latency BRAM controller.
- Adds a parametrised BRAM read latency and a credit-based read response FIFO, so reads sustain one per cycle under rready backpressure.
- Adds read/write round-robin arbitration and SLVERR on out-of-range addresses.
- Sits behind axi_to_lite, or directly on an AXI-lite crossbar port, in front of a BRAM macro.

---
 rtl/axi_lite_bram_pkg.sv | 13 +
 rtl/bram_rsp_fifo.sv | 56 +++++
 rtl/axi_lite_bram_ctrl_pipe.sv | 153 +++++++++++++++
 tb/tb_axi_lite_bram_ctrl_pipe.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_bram_pkg.sv
// Shared types and helpers for the AXI-lite to BRAM controller.
package axi_lite_bram_pkg;

  typedef logic [1:0] resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_SLVERR = 2'b10;

  function automatic int unsigned byte_off_width(input int unsigned data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/bram_rsp_fifo.sv
// Read response FIFO; the head entry is presented straight from storage flops.
module bram_rsp_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 34
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push,
  input  logic [Width-1:0] wdata,
  input  logic             pop,
  output logic [Width-1:0] rdata,
  output logic             empty,
  output logic             full
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             pop_ok;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign pop_ok = pop && !empty;
  assign empty  = (count_q == '0);
  assign full   = (count_q == CntW'(Depth));
  assign rdata  = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop_ok) rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push, pop_ok})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: ;
      endcase
    end
  end

  // Credits bound the number of outstanding reads to Depth.
  overflow_a: assert property (@(posedge clk_i) disable iff (rst_i) !(push && full && !pop));

endmodule

// File: rtl/axi_lite_bram_ctrl_pipe.sv
// AXI-lite slave onto a single-port BRAM with pipelined reads and credit-based
// read response buffering.
module axi_lite_bram_ctrl_pipe
  import axi_lite_bram_pkg::*;
#(
  parameter int unsigned DataWidth     = 64,
  parameter int unsigned AddrWidth     = 64,
  parameter int unsigned BramAddrWidth = 10,
  parameter int unsigned RdLatency     = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [AddrWidth-1:0]     host_awaddr,
  input  logic [2:0]               host_awprot,
  input  logic                     host_awvalid,
  output logic                     host_awready,
  input  logic [DataWidth-1:0]     host_wdata,
  input  logic [DataWidth/8-1:0]   host_wstrb,
  input  logic                     host_wvalid,
  output logic                     host_wready,
  output logic [1:0]               host_bresp,
  output logic                     host_bvalid,
  input  logic                     host_bready,
  input  logic [AddrWidth-1:0]     host_araddr,
  input  logic [2:0]               host_arprot,
  input  logic                     host_arvalid,
  output logic                     host_arready,
  output logic [DataWidth-1:0]     host_rdata,
  output logic [1:0]               host_rresp,
  output logic                     host_rvalid,
  input  logic                     host_rready,
  output logic                     bram_en,
  output logic [DataWidth/8-1:0]   bram_we,
  output logic [BramAddrWidth-1:0] bram_addr,
  output logic [DataWidth-1:0]     bram_wrdata,
  input  logic [DataWidth-1:0]     bram_rddata
);

  localparam int unsigned OffWidth  = byte_off_width(DataWidth);
  localparam int unsigned TopLsb    = OffWidth + BramAddrWidth;
  localparam int unsigned FifoDepth = RdLatency + 2;
  localparam int unsigned CredW     = $clog2(FifoDepth + 1);

  logic                 b_valid_q;
  resp_t                b_resp_q;
  logic [CredW-1:0]     credits_q, credits_d;
  logic                 prio_wr_q;
  logic                 rd_issue_q, rd_err_q;
  logic [RdLatency-1:0] pipe_vld_q, pipe_err_q;

  logic wr_oor, rd_oor, credit_ret, wr_cand, rd_cand, wr_grant, rd_grant;
  logic fifo_empty, fifo_full;
  logic [DataWidth+1:0] fifo_wdata, fifo_rdata;

  assign wr_oor = |(host_awaddr >> TopLsb);
  assign rd_oor = |(host_araddr >> TopLsb);

  assign credit_ret = host_rvalid && host_rready;
  assign wr_cand    = host_awvalid && host_wvalid && (!b_valid_q || host_bready);
  assign rd_cand    = host_arvalid && ((credits_q != '0) || credit_ret);
  assign wr_grant   = wr_cand && (!rd_cand || prio_wr_q);
  assign rd_grant   = rd_cand && (!wr_cand || !prio_wr_q);

  assign host_awready = wr_grant;
  assign host_wready  = wr_grant;
  assign host_arready = rd_grant;
  assign host_bvalid  = b_valid_q;
  assign host_bresp   = b_resp_q;

  always_comb begin
    credits_d = credits_q;
    case ({rd_grant, credit_ret})
      2'b10:   credits_d = credits_q - CredW'(1);
      2'b01:   credits_d = credits_q + CredW'(1);
      default: credits_d = credits_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      b_valid_q   <= 1'b0;
      b_resp_q    <= RESP_OKAY;
      credits_q   <= CredW'(FifoDepth);
      prio_wr_q   <= 1'b1;
      bram_en     <= 1'b0;
      bram_we     <= '0;
      bram_addr   <= '0;
      bram_wrdata <= '0;
      rd_issue_q  <= 1'b0;
      rd_err_q    <= 1'b0;
      pipe_vld_q  <= '0;
      pipe_err_q  <= '0;
    end else begin
      credits_q <= credits_d;
      // Only contention moves the arbiter, so the loser of a tie goes first next time.
      if (wr_cand && rd_cand) prio_wr_q <= !prio_wr_q;

      if (wr_grant) begin
        b_valid_q <= 1'b1;
        b_resp_q  <= wr_oor ? RESP_SLVERR : RESP_OKAY;
      end else if (host_bready) begin
        b_valid_q <= 1'b0;
      end

      bram_en <= 1'b0;
      bram_we <= '0;
      if (wr_grant) begin
        bram_en     <= !wr_oor;
        bram_we     <= wr_oor ? '0 : host_wstrb;
        bram_addr   <= host_awaddr[TopLsb-1:OffWidth];
        bram_wrdata <= host_wdata;
      end else if (rd_grant) begin
        bram_en   <= !rd_oor;
        bram_addr <= host_araddr[TopLsb-1:OffWidth];
      end

      rd_issue_q    <= rd_grant;
      rd_err_q      <= rd_grant && rd_oor;
      pipe_vld_q[0] <= rd_issue_q;
      pipe_err_q[0] <= rd_err_q;
      for (int i = 1; i < int'(RdLatency); i++) begin
        pipe_vld_q[i] <= pipe_vld_q[i-1];
        pipe_err_q[i] <= pipe_err_q[i-1];
      end
    end
  end

  assign fifo_wdata = pipe_err_q[RdLatency-1] ? {{DataWidth{1'b0}}, RESP_SLVERR}
                                              : {bram_rddata, RESP_OKAY};

  bram_rsp_fifo #(
    .Depth (FifoDepth),
    .Width (DataWidth + 2)
  ) u_rsp_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (pipe_vld_q[RdLatency-1]),
    .wdata (fifo_wdata),
    .pop   (credit_ret),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign host_rvalid = !fifo_empty;
  assign host_rdata  = fifo_rdata[DataWidth+1:2];
  assign host_rresp  = fifo_rdata[1:0];

  logic unused_ok;
  assign unused_ok = ^{host_awprot, host_arprot, fifo_full,
                       host_awaddr[OffWidth-1:0], host_araddr[OffWidth-1:0]};

endmodule

// File: tb/tb_axi_lite_bram_ctrl_pipe.sv
// Scoreboard bench: three controller instances (read latency 2, 1, 4), each with its own
// BRAM model, stimulus process and response monitor.
module tb_axi_lite_bram_ctrl_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_lat
    localparam int unsigned L = (g == 0) ? 2 : (g == 1) ? 1 : 4;

    logic        rst;
    logic [31:0] awaddr, wdata, araddr, rdata, bram_wrdata, bram_rddata;
    logic [3:0]  wstrb, bram_we;
    logic [1:0]  bresp, rresp;
    logic [9:0]  bram_addr;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready, bram_en;

    logic [33:0] rd_exp [$];
    logic [1:0]  wr_exp [$];
    logic [31:0] ref_mem [1024];
    int          accepted;

    axi_lite_bram_ctrl_pipe #(
      .DataWidth     (32),
      .AddrWidth     (32),
      .BramAddrWidth (10),
      .RdLatency     (L)
    ) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .host_awaddr  (awaddr),
      .host_awprot  (3'b000),
      .host_awvalid (awvalid),
      .host_awready (awready),
      .host_wdata   (wdata),
      .host_wstrb   (wstrb),
      .host_wvalid  (wvalid),
      .host_wready  (wready),
      .host_bresp   (bresp),
      .host_bvalid  (bvalid),
      .host_bready  (bready),
      .host_araddr  (araddr),
      .host_arprot  (3'b000),
      .host_arvalid (arvalid),
      .host_arready (arready),
      .host_rdata   (rdata),
      .host_rresp   (rresp),
      .host_rvalid  (rvalid),
      .host_rready  (rready),
      .bram_en      (bram_en),
      .bram_we      (bram_we),
      .bram_addr    (bram_addr),
      .bram_wrdata  (bram_wrdata),
      .bram_rddata  (bram_rddata)
    );

    // BRAM model: read-before-write, data out L cycles after the enable cycle.
    logic [31:0] bmem [1024];
    logic [31:0] dly [L];
    always @(posedge clk) begin
      if (bram_en)
        for (int b = 0; b < 4; b++)
          if (bram_we[b]) bmem[bram_addr][b*8 +: 8] <= bram_wrdata[b*8 +: 8];
      dly[0] <= bmem[bram_addr];
      for (int k = 1; k < int'(L); k++) dly[k] <= dly[k-1];
    end
    assign bram_rddata = dly[L-1];

    always begin
      @(negedge clk);
      #2;
      if (!rst && rvalid && rready) begin
        if (rd_exp.size() == 0) check($sformatf("L%0d unexpected rvalid", L), 64'(1), 64'(0));
        else check($sformatf("L%0d rdata/rresp", L), 64'({rdata, rresp}),
                   64'(rd_exp.pop_front()));
      end
      if (!rst && bvalid && bready) begin
        if (wr_exp.size() == 0) check($sformatf("L%0d unexpected bvalid", L), 64'(1), 64'(0));
        else check($sformatf("L%0d bresp", L), 64'(bresp), 64'(wr_exp.pop_front()));
      end
    end

    function automatic logic [33:0] rd_model(input logic [31:0] a);
      if (a[31:12] != '0) return {32'h0, 2'b10};
      return {ref_mem[a[11:2]], 2'b00};
    endfunction

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      bit ok = 1'b0;
      @(negedge clk);
      awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
      for (int t = 0; t < 50; t++) begin
        #1;
        if (awready && wready) begin ok = 1'b1; break; end
        @(negedge clk);
      end
      if (ok) begin
        if (a[31:12] == '0) begin
          for (int b = 0; b < 4; b++) if (s[b]) ref_mem[a[11:2]][b*8 +: 8] = d[b*8 +: 8];
          wr_exp.push_back(2'b00);
        end else begin
          wr_exp.push_back(2'b10);
        end
      end
      check($sformatf("L%0d wr handshake", L), 64'(ok), 64'(1));
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0;
    endtask

    // Returns at the falling edge of the cycle after the last handshake.
    task automatic rd_burst(input int n, input logic [31:0] base);
      int i = 0;
      @(negedge clk);
      araddr = base; arvalid = 1'b1;
      for (int t = 0; t < 200 && i < n; t++) begin
        #1;
        if (arready) begin rd_exp.push_back(rd_model(araddr)); i++; accepted++; end
        @(negedge clk);
        araddr = base + 32'(4 * i);
      end
      arvalid = 1'b0;
      check($sformatf("L%0d reads accepted", L), 64'(i), 64'(n));
    endtask

    task automatic rd_latency(input logic [31:0] a);
      int lat = 1;
      rd_burst(1, a);
      for (int t = 0; t < 20; t++) begin
        #1;
        if (rvalid) break;
        @(negedge clk);
        lat++;
      end
      check($sformatf("L%0d read latency", L), 64'(lat), 64'(L + 2));
    endtask

    task automatic drain(input string tag);
      for (int t = 0; t < 100 && (rd_exp.size() + wr_exp.size()) != 0; t++) @(negedge clk);
      check($sformatf("L%0d %s drain", L, tag), 64'(rd_exp.size() + wr_exp.size()), 64'(0));
      repeat (2) @(negedge clk);
    endtask

    task automatic burst_check(input string tag);
      accepted = 0;
      rready = 1'b0;
      fork
        rd_burst(8, 32'h100);
        begin
          int seen = 0;
          repeat (12) @(negedge clk);
          check($sformatf("L%0d %s credit block", L, tag), 64'(accepted), 64'(L + 2));
          rready = 1'b1;
          for (int k = 0; k < 8; k++) begin
            #1;
            if (rvalid) seen++;
            @(negedge clk);
          end
          check($sformatf("L%0d %s throughput", L, tag), 64'(seen), 64'(8));
        end
      join
      drain(tag);
    endtask

    initial begin
      int nw, nr, sw, bad, cur, last;
      rst = 1'b1;
      awaddr = '0; wdata = '0; wstrb = '0; awvalid = 1'b0; wvalid = 1'b0;
      araddr = '0; arvalid = 1'b0; bready = 1'b1; rready = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      check($sformatf("L%0d reset outputs", L),
            64'({rvalid, bvalid, bram_en, bram_we, bram_addr, rdata, rresp, bresp,
                 awready, wready, arready}), 64'(0));
      @(negedge clk);
      rst = 1'b0;

      // Single write: BRAM port driven the following cycle.
      wr(32'h10, 32'hDEADBEEF, 4'hF);
      #1;
      check($sformatf("L%0d wr bram_en", L), 64'(bram_en), 64'(1));
      check($sformatf("L%0d wr bram_we", L), 64'(bram_we), 64'(4'hF));
      check($sformatf("L%0d wr bram_addr", L), 64'(bram_addr), 64'(4));
      check($sformatf("L%0d wr bram_wrdata", L), 64'(bram_wrdata), 64'(32'hDEADBEEF));
      check($sformatf("L%0d bvalid", L), 64'(bvalid), 64'(1));
      rd_latency(32'h10);
      drain("t2");

      for (int i = 0; i < 8; i++) wr(32'h100 + 32'(4 * i), 32'hA5A50000 + 32'(i), 4'hF);
      wr(32'h104, 32'h11223344, 4'b0101);
      wr(32'hFFC, 32'h0BADF00D, 4'hF);
      rd_latency(32'hFFC);
      drain("top word");

      burst_check("t3");

      // Write and read contend every cycle.
      @(negedge clk);
      awaddr = 32'h50; wdata = 32'hC0FFEE00; wstrb = 4'hF; araddr = 32'h10;
      awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
      nw = 0; nr = 0; sw = 0; bad = 0; last = 0;
      for (int c = 0; c < 10; c++) begin
        #1;
        cur = 0;
        if (awready && wready) begin
          cur = 1; nw++;
          ref_mem[20] = 32'hC0FFEE00;
          wr_exp.push_back(2'b00);
        end
        if (arready) begin
          cur = (cur == 1) ? 3 : 2; nr++;
          rd_exp.push_back(rd_model(araddr));
        end
        if (awready != wready) bad++;
        if (c > 0 && cur != last && cur inside {1, 2} && last inside {1, 2}) sw++;
        last = cur;
        @(negedge clk);
      end
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      check($sformatf("L%0d arb writes", L), 64'(nw), 64'(5));
      check($sformatf("L%0d arb reads", L), 64'(nr), 64'(5));
      check($sformatf("L%0d arb alternations", L), 64'(sw), 64'(9));
      check($sformatf("L%0d aw/w ready split", L), 64'(bad), 64'(0));
      drain("t4");

      // Out-of-range accesses never touch the BRAM.
      rd_burst(1, 32'h1000);
      #1;
      check($sformatf("L%0d oor rd bram_en", L), 64'(bram_en), 64'(0));
      wr(32'h2000, 32'hFFFFFFFF, 4'hF);
      #1;
      check($sformatf("L%0d oor wr bram_en/we", L), 64'({bram_en, bram_we}), 64'(0));
      drain("t5");

      // Reset with a write response and reads outstanding.
      bready = 1'b0;
      wr(32'h20, 32'h12345678, 4'hF);
      rready = 1'b0;
      rd_burst(3, 32'h100);
      #1;
      check($sformatf("L%0d bvalid before rst", L), 64'(bvalid), 64'(1));
      rst = 1'b1;
      #1;
      check($sformatf("L%0d valids in rst", L), 64'({rvalid, bvalid}), 64'(0));
      rd_exp.delete();
      wr_exp.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      bready = 1'b1;
      burst_check("t6");
      rd_latency(32'h20);
      drain("t6 rd");

      done_cnt++;
    end
  end

  initial begin
    for (int t = 0; t < 20000 && done_cnt < 3; t++) @(posedge clk);
    check("all benches finished", 64'(done_cnt), 64'(3));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
